// File: rtl/hex_line_sequencer.sv
// Record-to-text line sequencer: (addr, data) -> "AAAA:DD\r\n".
// One shared nibble encoder; registered byte-stream output.

module hex_nibble_enc (
  input  logic [3:0] nib,
  output logic [7:0] ch
);

  // 0-9 map to '0'-'9', A-F map to 'A'-'F'
  always_comb begin
    if (nib < 4'd10) ch = 8'h30 + {4'h0, nib};
    else             ch = 8'h37 + {4'h0, nib};
  end

endmodule

module hex_line_sequencer #(
  parameter int ADDR_NIBBLES = 4,
  parameter int DATA_NIBBLES = 2,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_NIBBLES*4-1:0] in_addr,
  input  logic [DATA_NIBBLES*4-1:0] in_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [7:0]                tx_byte,
  output logic                      busy,
  output logic [COUNT_WIDTH-1:0]    line_count
);

  localparam int AW   = ADDR_NIBBLES * 4;
  localparam int DW   = DATA_NIBBLES * 4;
  localparam int MAXN = (ADDR_NIBBLES > DATA_NIBBLES) ?
                        ADDR_NIBBLES : DATA_NIBBLES;
  localparam int IW   = (MAXN > 1) ? $clog2(MAXN) : 1;

  localparam logic [IW-1:0] ALAST = IW'(ADDR_NIBBLES - 1);
  localparam logic [IW-1:0] DLAST = IW'(DATA_NIBBLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    COLON,
    DATA,
    CR,
    LF
  } state_t;

  state_t        state;
  logic [AW-1:0] haddr;
  logic [DW-1:0] hdata;
  logic [IW-1:0] idx;
  logic          xfer;
  logic [3:0]    nib;
  logic [7:0]    enc;
  logic [AW-1:0] ash;
  logic [DW-1:0] dsh;
  int            apos;
  int            dpos;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign xfer     = tx_valid && tx_ready;

  hex_nibble_enc u_enc (
    .nib (nib),
    .ch  (enc)
  );

  // Select the nibble for the character loaded on the next transfer
  always_comb begin
    ash  = '0;
    dsh  = '0;
    nib  = '0;
    apos = ADDR_NIBBLES - 2 - int'(idx);
    dpos = DATA_NIBBLES - 2 - int'(idx);
    if (apos < 0) apos = 0;
    if (dpos < 0) dpos = 0;
    case (state)
      IDLE: begin
        ash = in_addr >> (4 * (ADDR_NIBBLES - 1));
        nib = ash[3:0];
      end
      ADDR: begin
        ash = haddr >> (4 * apos);
        nib = ash[3:0];
      end
      COLON: begin
        dsh = hdata >> (4 * (DATA_NIBBLES - 1));
        nib = dsh[3:0];
      end
      DATA: begin
        dsh = hdata >> (4 * dpos);
        nib = dsh[3:0];
      end
      default: nib = '0;
    endcase
  end

  // Line FSM with registered character output and line counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      haddr      <= '0;
      hdata      <= '0;
      idx        <= '0;
      tx_valid   <= 1'b0;
      tx_byte    <= 8'h00;
      line_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            haddr    <= in_addr;
            hdata    <= in_data;
            idx      <= '0;
            state    <= ADDR;
            tx_valid <= 1'b1;
            tx_byte  <= enc;
          end
        end
        ADDR: begin
          if (xfer) begin
            if (idx == ALAST) begin
              state   <= COLON;
              tx_byte <= 8'h3A;
            end else begin
              idx     <= idx + 1'b1;
              tx_byte <= enc;
            end
          end
        end
        COLON: begin
          if (xfer) begin
            state   <= DATA;
            idx     <= '0;
            tx_byte <= enc;
          end
        end
        DATA: begin
          if (xfer) begin
            if (idx == DLAST) begin
              state   <= CR;
              tx_byte <= 8'h0D;
            end else begin
              idx     <= idx + 1'b1;
              tx_byte <= enc;
            end
          end
        end
        CR: begin
          if (xfer) begin
            state   <= LF;
            tx_byte <= 8'h0A;
          end
        end
        LF: begin
          if (xfer) begin
            state      <= IDLE;
            tx_valid   <= 1'b0;
            line_count <= line_count + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hex_line_sequencer.sv
// Bench for hex_line_sequencer: queue model of the text line,
// per-cycle compare, plus literal line and counter checks.

module tb_hex_line_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        tx_ready = 1'b1;
  logic [15:0] in_addr = '0;
  logic [7:0]  in_data = '0;

  logic        in_ready, tx_valid, busy;
  logic [7:0]  tx_byte;
  logic [15:0] line_count;

  logic        in_ready2, tx_valid2, busy2;
  logic [7:0]  tx_byte2;
  logic [1:0]  lc2;

  hex_line_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_byte    (tx_byte),
    .busy       (busy),
    .line_count (line_count)
  );

  hex_line_sequencer #(.COUNT_WIDTH(2)) dut2 (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready2),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .tx_valid   (tx_valid2),
    .tx_ready   (tx_ready),
    .tx_byte    (tx_byte2),
    .busy       (busy2),
    .line_count (lc2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic [7:0] got[$];
  bit         mbusy = 1'b0;
  bit         pb;
  int         mcount = 0;
  int         caps = 0;
  int         cyc = 0;
  bit         armed = 1'b0;
  bit         stall = 1'b0;
  logic [7:0] pbyte = '0;
  int         lf_cyc = -1;
  int         cap_cyc = -1;
  bit         rmode = 1'b0;

  function automatic logic [7:0] hexch(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h41 + {4'h0, n} - 8'd10;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Model: one text line per accepted record, popped per transfer
  always @(posedge clk) begin
    pb    = mbusy;
    stall = armed && !reset && tx_valid && !tx_ready;
    pbyte = tx_byte;
    if (armed && !reset && tx_valid && tx_ready) begin
      got.push_back(tx_byte);
      if (tx_byte == 8'h0A) lf_cyc = cyc;
    end
    if (armed && !reset && in_valid && in_ready) cap_cyc = cyc;
    if (reset) begin
      q.delete();
      mbusy  = 1'b0;
      mcount = 0;
      armed  = 1'b1;
    end else begin
      if (q.size() > 0 && tx_ready) begin
        if (q[0] == 8'h0A) begin
          mbusy = 1'b0;
          mcount++;
        end
        void'(q.pop_front());
      end
      if (!pb && in_valid) begin
        for (int i = 3; i >= 0; i--)
          q.push_back(hexch(in_addr[i*4 +: 4]));
        q.push_back(8'h3A);
        for (int i = 1; i >= 0; i--)
          q.push_back(hexch(in_data[i*4 +: 4]));
        q.push_back(8'h0D);
        q.push_back(8'h0A);
        mbusy = 1'b1;
        caps++;
      end
    end
    cyc++;
  end

  // Compare both instances against the model every cycle
  always @(negedge clk) begin
    if (armed) begin
      chk("tx_valid", 32'(tx_valid), 32'(q.size() > 0));
      chk("tx_valid_w2", 32'(tx_valid2), 32'(q.size() > 0));
      if (q.size() > 0) begin
        chk("tx_byte", 32'(tx_byte), 32'(q[0]));
        chk("tx_byte_w2", 32'(tx_byte2), 32'(q[0]));
      end
      chk("in_ready", 32'(in_ready), 32'(!mbusy));
      chk("busy", 32'(busy), 32'(mbusy));
      chk("busy_w2", 32'(busy2), 32'(mbusy));
      chk("line_count", 32'(line_count), 32'(mcount[15:0]));
      chk("line_count_w2", 32'(lc2), 32'(mcount[1:0]));
      if (stall)
        chk("stall_hold", {23'd0, tx_valid, tx_byte},
            {23'd0, 1'b1, pbyte});
    end
  end

  // Consumer readiness: always ready, or random stalls
  always @(negedge clk) begin
    if (rmode) tx_ready = 1'($urandom_range(0, 1));
    else       tx_ready = 1'b1;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    got.delete();
  endtask

  task automatic send(input logic [15:0] a, input logic [7:0] d);
    int c0;
    int n;
    c0 = caps;
    n  = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    do begin
      @(negedge clk);
      n++;
    end while (caps == c0 && n < 100);
    in_valid = 1'b0;
    chk("capture_timeout", 32'(caps == c0), 32'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((mbusy || q.size() > 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(mbusy), 32'd0);
  endtask

  task automatic expect9(input string name, input logic [7:0] e[9]);
    chk({name, "_len"}, 32'(got.size()), 32'd9);
    for (int i = 0; i < 9; i++)
      if (i < got.size())
        chk(name, 32'(got[i]), 32'(e[i]));
    got.delete();
  endtask

  logic [7:0] e18[18];
  logic [1:0] lcexp[5];

  initial begin
    e18 = '{8'h42, 8'h45, 8'h45, 8'h46, 8'h3A, 8'h31, 8'h32,
            8'h0D, 8'h0A, 8'h30, 8'h34, 8'h32, 8'h30, 8'h3A,
            8'h37, 8'h45, 8'h0D, 8'h0A};
    lcexp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    repeat (2) @(negedge clk);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_byte", 32'(tx_byte), 32'h00);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_line_count", 32'(line_count), 32'd0);
    reset = 1'b0;

    send(16'h1A2F, 8'h3C);
    wait_idle();
    chk("t1_latency", 32'(lf_cyc - cap_cyc), 32'd9);
    chk("t1_idle", {30'd0, tx_valid, in_ready}, 32'b01);
    chk("t1_count", 32'(line_count), 32'd1);
    expect9("t1_line", '{8'h31, 8'h41, 8'h32, 8'h46, 8'h3A,
                         8'h33, 8'h43, 8'h0D, 8'h0A});

    send(16'hFFFF, 8'h00);
    wait_idle();
    expect9("t2a_line", '{8'h46, 8'h46, 8'h46, 8'h46, 8'h3A,
                          8'h30, 8'h30, 8'h0D, 8'h0A});
    send(16'h0009, 8'hA0);
    wait_idle();
    expect9("t2b_line", '{8'h30, 8'h30, 8'h30, 8'h39, 8'h3A,
                          8'h41, 8'h30, 8'h0D, 8'h0A});

    rmode = 1'b1;
    send(16'h1A2F, 8'h3C);
    wait_idle();
    rmode = 1'b0;
    expect9("t3_line", '{8'h31, 8'h41, 8'h32, 8'h46, 8'h3A,
                         8'h33, 8'h43, 8'h0D, 8'h0A});

    do_reset();
    begin
      int c0;
      int n;
      c0 = caps;
      n  = 0;
      in_valid = 1'b1;
      in_addr  = 16'hBEEF;
      in_data  = 8'h12;
      do begin
        @(negedge clk);
        n++;
      end while (caps == c0 && n < 50);
      in_addr = 16'h0420;
      in_data = 8'h7E;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (caps < c0 + 2 && n < 50);
      in_valid = 1'b0;
      chk("t4_caps", 32'(caps - c0), 32'd2);
      chk("t4_b2b", 32'(cap_cyc), 32'(lf_cyc + 1));
    end
    wait_idle();
    chk("t4_len", 32'(got.size()), 32'd18);
    for (int i = 0; i < 18; i++)
      if (i < got.size())
        chk("t4_line", 32'(got[i]), 32'(e18[i]));
    chk("t4_count", 32'(line_count), 32'd2);
    got.delete();

    send(16'h1234, 8'h56);
    begin
      int n;
      n = 0;
      while (!(tx_valid && tx_byte == 8'h3A) && n < 30) begin
        @(negedge clk);
        n++;
      end
      chk("t5_colon_seen", 32'(tx_byte), 32'h3A);
    end
    reset    = 1'b1;
    in_valid = 1'b1;
    in_addr  = 16'h5555;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("t5_tx_valid", 32'(tx_valid), 32'd0);
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    chk("t5_count", 32'(line_count), 32'd0);
    chk("t5_no_capture", 32'(busy), 32'd0);
    got.delete();
    send(16'h0ABC, 8'hDE);
    wait_idle();
    expect9("t5_line", '{8'h30, 8'h41, 8'h42, 8'h43, 8'h3A,
                         8'h44, 8'h45, 8'h0D, 8'h0A});

    do_reset();
    for (int k = 0; k < 5; k++) begin
      send(16'h1111 * 16'(k), 8'(k));
      wait_idle();
      chk("t6_wrap", 32'(lc2), 32'(lcexp[k]));
    end
    got.delete();

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
